// File: rtl/router_out_sched_if.sv
// Handshake bundle between the three input FIFOs, the output scheduler and the downstream sink.
// master = scheduler side, slave = FIFO/sink side.
interface router_out_sched_if #(
    parameter int DATA_W = 8
);
    logic              vld_out_0, vld_out_1, vld_out_2;
    logic [DATA_W-1:0] data_out_0, data_out_1, data_out_2;
    logic              read_enb_0, read_enb_1, read_enb_2;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic [1:0]        out_chan;
    logic              sched_err;

    modport master (
        input  vld_out_0, vld_out_1, vld_out_2,
        input  data_out_0, data_out_1, data_out_2,
        input  out_ready,
        output read_enb_0, read_enb_1, read_enb_2,
        output out_valid, out_data, out_sop, out_eop, out_chan, sched_err
    );

    modport slave (
        output vld_out_0, vld_out_1, vld_out_2,
        output data_out_0, data_out_1, data_out_2,
        output out_ready,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  out_valid, out_data, out_sop, out_eop, out_chan, sched_err
    );
endinterface

// File: rtl/router_out_sched.sv
// Round-robin packet scheduler draining three router FIFOs into one credit-limited output stream.
// Optional stall-abort feature: define ROUTER_SCHED_TIMEOUT_EN.
module router_out_sched #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    router_out_sched_if.master bus
);
    localparam int REM_W = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, HDR, HWAIT, BODY} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [1:0]        chan;
    } word_t;

    state_e            state_q;
    logic [1:0]        grant_q, last_q;
    logic [REM_W-1:0]  rem_q;
    logic              inflight_q, tag_sop_q, tag_eop_q;
    logic [1:0]        tag_chan_q;
    word_t             buf_q [2];
    word_t             buf_d [2];
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        vld;
    logic              vld_g;
    logic [DATA_W-1:0] fifo_rdata;
    logic [2:0]        occ;
    logic              out_valid, pop, credit, rd, abort;

    function automatic logic [1:0] inc3(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // Search order last+1, last+2, last (all mod 3).
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] c, pick;
        logic       found;
        c     = last;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c = inc3(c);
            if (!found && req[c]) begin
                pick  = c;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign vld   = {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
    assign vld_g = vld[grant_q];

    // The word arriving this cycle always comes from the channel that was read last cycle.
    always_comb begin
        unique case (tag_chan_q)
            2'd1:    fifo_rdata = bus.data_out_1;
            2'd2:    fifo_rdata = bus.data_out_2;
            default: fifo_rdata = bus.data_out_0;
        endcase
    end

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && bus.out_ready;
    assign occ       = 3'(cnt_q) + 3'(inflight_q);
    assign credit    = (occ - 3'(pop)) < 3'd2;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        rd = 1'b0;
        if (!reset) begin
            unique case (state_q)
                HDR:     rd = vld_g && credit;
                BODY:    rd = (rem_q != '0) && vld_g && credit;
                default: rd = 1'b0;
            endcase
        end
    end

    assign bus.read_enb_0 = rd && (grant_q == 2'd0);
    assign bus.read_enb_1 = rd && (grant_q == 2'd1);
    assign bus.read_enb_2 = rd && (grant_q == 2'd2);

    // Shift-down buffer: entry 0 is the presented word; an abort flags whichever entry ends up last.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        if (inflight_q) begin
            buf_d[cnt_d[0]] = '{data: fifo_rdata, sop: tag_sop_q, eop: tag_eop_q, chan: tag_chan_q};
            cnt_d           = cnt_d + 2'd1;
        end
        if (abort && (cnt_d != 2'd0)) begin
            buf_d[cnt_d[1]].eop = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'd0;
            last_q     <= 2'd2;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            tag_sop_q  <= 1'b0;
            tag_eop_q  <= 1'b0;
            tag_chan_q <= 2'd0;
            cnt_q      <= 2'd0;
            // NOTE: buffer data is reset as well, since out_data must read 0 out of reset.
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            inflight_q <= rd;
            tag_sop_q  <= (state_q == HDR);
            tag_eop_q  <= (state_q == BODY) && (rem_q == REM_W'(1));
            tag_chan_q <= grant_q;
            unique case (state_q)
                IDLE: begin
                    if (vld != 3'b000) begin
                        grant_q <= rr_pick(last_q, vld);
                        last_q  <= rr_pick(last_q, vld);
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (abort)   state_q <= IDLE;
                    else if (rd) state_q <= HWAIT;
                end
                HWAIT: begin
                    rem_q   <= REM_W'(fifo_rdata[DATA_W-1:2]) + REM_W'(1);
                    state_q <= BODY;
                end
                BODY: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (rd) begin
                        rem_q <= rem_q - REM_W'(1);
                        if (rem_q == REM_W'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ROUTER_SCHED_TIMEOUT_EN
    logic [7:0] stall_q;
    logic       sched_err_q;
    logic       waiting;

    assign waiting = (state_q == HDR) || (state_q == BODY);
    // A read clears the count, so nothing is ever in flight when the abort fires.
    assign abort   = waiting && !vld_g && (stall_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q     <= 8'd0;
            sched_err_q <= 1'b0;
        end else begin
            sched_err_q <= abort;
            if (waiting && !vld_g && !abort) stall_q <= stall_q + 8'd1;
            else                             stall_q <= 8'd0;
        end
    end

    assign bus.sched_err = sched_err_q;
`else
    assign abort         = 1'b0;
    assign bus.sched_err = 1'b0;
`endif

    assign bus.out_valid = out_valid;
    assign bus.out_data  = buf_q[0].data;
    assign bus.out_sop   = buf_q[0].sop;
    assign bus.out_eop   = buf_q[0].eop;
    assign bus.out_chan  = buf_q[0].chan;
endmodule

// File: tb/tb_router_out_sched.sv
// Directed bench for router_out_sched: FIFO models feed packets, a scoreboard queue checks the output stream.
module tb_router_out_sched;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [1:0] chan;
    } word_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    router_out_sched_if #(.DATA_W(DATA_W)) bus ();

    router_out_sched #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    pops = 0;
    int    err_pulses = 0;
    word_t exp_q [$];

    // FIFO models: read data appears the cycle after read_enb.
    logic [7:0] mem [3][256];
    logic [7:0] rp [3];
    logic [7:0] wp [3];

    initial begin
        for (int c = 0; c < 3; c++) begin
            rp[c] = 8'd0;
            wp[c] = 8'd0;
        end
    end

    assign bus.vld_out_0 = rp[0] < wp[0];
    assign bus.vld_out_1 = rp[1] < wp[1];
    assign bus.vld_out_2 = rp[2] < wp[2];

    always @(posedge clock) begin
        if (bus.read_enb_0) begin
            bus.data_out_0 <= mem[0][rp[0]];
            rp[0]          <= rp[0] + 8'd1;
        end
        if (bus.read_enb_1) begin
            bus.data_out_1 <= mem[1][rp[1]];
            rp[1]          <= rp[1] + 8'd1;
        end
        if (bus.read_enb_2) begin
            bus.data_out_2 <= mem[2][rp[2]];
            rp[2]          <= rp[2] + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic fifo_w(input int ch, input logic [7:0] d);
        mem[ch][wp[ch]] = d;
        wp[ch]          = wp[ch] + 8'd1;
    endtask

    task automatic exp_w(input int ch, input logic [7:0] d, input logic sop, input logic eop);
        exp_q.push_back('{data: d, sop: sop, eop: eop, chan: 2'(ch)});
    endtask

    task automatic put(input int ch, input logic [7:0] d, input logic sop, input logic eop);
        fifo_w(ch, d);
        exp_w(ch, d, sop, eop);
    endtask

    task automatic send_pkt(input int ch, input logic [7:0] hdr, input logic [7:0] seed);
        int         len;
        logic [7:0] par;
        len = int'(hdr[7:2]);
        par = hdr;
        put(ch, hdr, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) begin
            put(ch, seed + 8'(i), 1'b0, 1'b0);
            par = par ^ (seed + 8'(i));
        end
        put(ch, par, 1'b0, 1'b1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, bus.out_valid, 1'b0);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    // Output monitor: scoreboard pops, hold-while-stalled and read-enable legality.
    word_t prev_w;
    logic  prev_v = 1'b0;
    logic  prev_r = 1'b0;

    always @(negedge clock) begin
        word_t cur;
        logic  viol;
        #2;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            cur  = '{data: bus.out_data, sop: bus.out_sop, eop: bus.out_eop, chan: bus.out_chan};
            viol = (bus.read_enb_0 && !bus.vld_out_0) || (bus.read_enb_1 && !bus.vld_out_1) ||
                   (bus.read_enb_2 && !bus.vld_out_2) ||
                   ((32'(bus.read_enb_0) + 32'(bus.read_enb_1) + 32'(bus.read_enb_2)) > 32'd1);
            check("rd_legal", viol, 1'b0);
            if (bus.sched_err) err_pulses++;
            if (prev_v && !prev_r) check("hold", {bus.out_valid, cur}, {1'b1, prev_w});
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                if (exp_q.size() == 0) check("spurious_word", exp_q.size(), 1);
                else                   check("word", cur, exp_q.pop_front());
            end
            prev_w = cur;
            prev_v = bus.out_valid;
            prev_r = bus.out_ready;
        end
    end

    initial begin
        int t_rd;
        int cyc;
        int mark;
        int found;
        int k;

        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) step();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_sop_eop", {bus.out_sop, bus.out_eop}, 2'b00);
        check("rst_chan", bus.out_chan, 2'd0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_err", bus.sched_err, 1'b0);
        check("rst_rd", {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0}, 3'b000);
        reset = 1'b0;

        // Len-5 packet from FIFO2: latency and framing.
        mark = pops;
        send_pkt(2, 8'h16, 8'h30);
        bus.out_ready = 1'b1;
        t_rd = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.read_enb_2) begin
                t_rd = i;
                break;
            end
        end
        check("rd2_seen", (t_rd >= 0), 1'b1);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cyc++;
            if (bus.out_valid) break;
        end
        check("latency", cyc, 2);
        wait_drain("len5", 100);
        check("len5_count", pops - mark, 7);

        // Round-robin order from reset, then refill.
        reset_pulse();
        send_pkt(0, 8'h04, 8'h40);
        send_pkt(1, 8'h05, 8'h50);
        send_pkt(2, 8'h06, 8'h60);
        wait_drain("rr1", 100);
        send_pkt(0, 8'h04, 8'h48);
        send_pkt(1, 8'h05, 8'h58);
        send_pkt(2, 8'h06, 8'h68);
        wait_drain("rr2", 100);

        // Len-14 packet with out_ready toggling every cycle.
        mark = pops;
        bus.out_ready = 1'b0;
        send_pkt(1, 8'h39, 8'h70);
        for (int i = 0; i < 300; i++) begin
            step();
            bus.out_ready = ~bus.out_ready;
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        bus.out_ready = 1'b1;
        wait_drain("toggle", 10);
        check("toggle_count", pops - mark, 16);

        // Len-0 packet: header then parity carrying eop.
        mark = pops;
        send_pkt(0, 8'h00, 8'h00);
        wait_drain("len0", 50);
        check("len0_count", pops - mark, 2);

`ifdef ROUTER_SCHED_TIMEOUT_EN
        // FIFO0 runs dry after two payload words; the held tail word must come out flagged eop.
        mark = pops;
        fifo_w(0, 8'h14);
        fifo_w(0, 8'hE0);
        fifo_w(0, 8'hE1);
        exp_w(0, 8'h14, 1'b1, 1'b0);
        exp_w(0, 8'hE0, 1'b0, 1'b0);
        exp_w(0, 8'hE1, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            step();
            if (pops != mark) break;
        end
        bus.out_ready = 1'b0;
        k = -1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (k < 0 && !bus.vld_out_0) k = 0;
            else if (k >= 0)             k++;
            if (bus.sched_err) break;
        end
        check("timeout_cycles", k, TIMEOUT);
        check("timeout_err", bus.sched_err, 1'b1);
        bus.out_ready = 1'b1;
        wait_drain("abort", 50);
        send_pkt(1, 8'h00, 8'h00);
        wait_drain("post_abort", 50);
`else
        // Source stalls mid-packet: scheduler simply waits, no error.
        mark = pops;
        fifo_w(0, 8'h08);
        fifo_w(0, 8'hF0);
        exp_w(0, 8'h08, 1'b1, 1'b0);
        exp_w(0, 8'hF0, 1'b0, 1'b0);
        exp_w(0, 8'hF1, 1'b0, 1'b0);
        exp_w(0, 8'h08 ^ 8'hF0 ^ 8'hF1, 1'b0, 1'b1);
        repeat (40) step();
        check("stall_partial", pops - mark, 2);
        fifo_w(0, 8'hF1);
        fifo_w(0, 8'h08 ^ 8'hF0 ^ 8'hF1);
        wait_drain("stall", 50);
        check("stall_count", pops - mark, 4);
`endif

        // Reset at the third payload word of a FIFO1 packet.
        send_pkt(1, 8'h14, 8'hC0);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.out_valid && bus.out_data == 8'hC2) begin
                found = 1;
                break;
            end
        end
        check("rst_point_seen", found, 1);
        reset = 1'b1;
        exp_q.delete();
        step();
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_err", bus.sched_err, 1'b0);
        check("midrst_rd", {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0}, 3'b000);
        wp[1] = rp[1];
        step();
        reset = 1'b0;
        send_pkt(0, 8'h04, 8'hD0);
        send_pkt(2, 8'h04, 8'hD8);
        wait_drain("post_rst", 100);

`ifdef ROUTER_SCHED_TIMEOUT_EN
        check("err_pulses", err_pulses, 1);
`else
        check("err_pulses", err_pulses, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
